bf_loop_scanner: RTL
====================

# bf_loop_scanner

Bracket-matching scanner for the BF machine control path. When the decoder hits `[` with a zero data cell, or `]` with a non-zero cell, it starts this block, which walks program memory forward or backward and counts nesting depth. The block reports the address of the matching bracket. Sequencing then loads PC from `match_pc`. It sits between the control FSM and the program-memory read port, and it owns that port while `busy` is high.

## Interface

Reset is synchronous, active-low, on a single clock.

Parameters:
- `DEPTH_W`, default 8: width of the nesting-depth counter. Maximum tracked depth is 2^DEPTH_W − 1.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `dir`  in  1  0 = forward (from `[`), 1 = backward (from `]`); sampled with `start`.
- `start_pc`  in  16  address of the originating bracket; sampled with `start`.
- `instr_addr`  out  16  program-memory read address (registered).
- `instr_data`  in  8  program-memory read data, valid one cycle after `instr_addr` changes (synchronous RAM).
- `busy`  out  1  high while scanning.
- `done`  out  1  one-cycle completion pulse.
- `match_pc`  out  16  address of the matching bracket; valid while `done` is high, held afterwards.
- `error`  out  1  pulses with `done` when the scan fails.

## Operation

States: IDLE, READ, EVAL.

- **IDLE.** On `start` = 1:
  - `depth` ← 1; latch `dir` and `start_pc`.
  - `instr_addr` ← `start_pc` + 1 (fwd) or `start_pc` − 1 (bwd).
  - Go to READ. `busy` ← 1.
  - If the first step would wrap (fwd from 0xFFFF, bwd from 0x0000), stay in IDLE and pulse `done` + `error` instead.
- **READ.** Memory samples `instr_addr`. Go to EVAL unconditionally.
- **EVAL.** Classify `instr_data`. Forward: `[` (0x5B) is "open", `]` (0x5D) is "close". Backward: the roles are swapped. Any other byte is ignored.
  - open: `depth` ← `depth` + 1. If `depth` is already at max: error exit.
  - close: `depth` ← `depth` − 1. If the result is 0: `match_pc` ← `instr_addr`, `done` ← 1, `busy` ← 0, go to IDLE.
  - No match yet: step `instr_addr` by ±1 and go to READ. If the step would wrap past 0xFFFF (fwd) or below 0x0000 (bwd): error exit.
- **Error exit.** `done` ← 1, `error` ← 1, `match_pc` ← latched `start_pc`, `busy` ← 0, go to IDLE.
- **Address arithmetic** is 16-bit unsigned. Wrap is detected before stepping and is never performed.
- **`start` while busy** (READ/EVAL) is ignored; there is no queuing.

## Timing

- **Reset values.** `instr_addr` = 0, `busy` = 0, `done` = 0, `error` = 0, `match_pc` = 0, `depth` = 0, state = IDLE.
- **Reset mid-scan.** Abort immediately. No `done` pulse; all outputs take their reset values on the next edge.
- **Latency.** Two cycles per character examined. With `start` sampled at edge 0 and the match k characters away, `done` is high for exactly the cycle after edge 2k.
- **`busy`** is high from edge 0 to edge 2k. It is low in the `done` cycle.
- **Back-to-back.** A new `start` is accepted in the same cycle `done` is high (the state is already IDLE).
- **`instr_addr`** changes only on entry to READ. `instr_data` is used only in EVAL.

## Structure

- Shared package `bf_pkg` holds:
  - `OP_LBRACK` = 8'h5B and `OP_RBRACK` = 8'h5D (shared with the decoder);
  - `DIR_FWD` = 1'b0 and `DIR_BWD` = 1'b1;
  - the scanner state enum.
- Address stepping instantiates the existing `PCALU` with `PCDecInc` = `dir`. Its output feeds `instr_addr`, with wrap checks done in this block. There are no other sub-modules.

## Test plan

- **Simple forward match.** Memory 0x10=`[`, 0x11=`+`, 0x12=`]`; `start`, `dir`=0, `start_pc`=0x10 → `done` at cycle 4, `match_pc`=0x12, `error`=0.
- **Nested backward match.** 0x20=`[`, 0x21=`[`, 0x22=`]`, 0x23=`]`; `dir`=1, `start_pc`=0x23 → skips the inner pair, `match_pc`=0x20, `done` at cycle 6.
- **Unmatched forward to end.** `start_pc`=0xFFFD=`[`, no `]` after it → `done`+`error` at cycle 4, `match_pc`=0xFFFD, `instr_addr` never reads 0x0000.
- **Depth overflow.** `DEPTH_W`=2; `[[[[` after the start bracket → `error` pulse on the EVAL that would exceed depth 3.
- **Busy behaviour.** Mid-scan: a second `start` with a different `start_pc` is ignored and the original match is returned. Separately, `resetn`=0 mid-scan gives no `done` and all outputs 0 next cycle; a fresh `start` then completes normally.
- **Back-to-back starts.** `start` asserted in the `done` cycle of a previous scan → accepted, `busy` is high the next cycle.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared BF control-path definitions: opcodes, scan direction and scanner states.
package bf_pkg;
    localparam logic [7:0] OP_LBRACK = 8'h5B;
    localparam logic [7:0] OP_RBRACK = 8'h5D;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EVAL
    } scan_state_e;

    // True when one more step from addr would leave the 16-bit address space.
    function automatic logic step_wraps(input logic [15:0] addr, input logic dir);
        return (dir == DIR_BWD) ? (addr == 16'h0000) : (addr == 16'hFFFF);
    endfunction
endpackage

// File: rtl/PCALU.sv
// Program-counter incrementer/decrementer shared by the control path.
module PCALU (
    input  logic [15:0] pc_in,
    input  logic        PCDecInc,
    output logic [15:0] pc_out
);
    assign pc_out = PCDecInc ? (pc_in - 16'd1) : (pc_in + 16'd1);
endmodule

// File: rtl/bf_loop_scanner.sv
// Walks program memory from a bracket to its partner, tracking nesting depth,
// and reports the matching address (or an error on overflow / address wrap).
module bf_loop_scanner
    import bf_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        dir,
    input  logic [15:0] start_pc,
    output logic [15:0] instr_addr,
    input  logic [7:0]  instr_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] match_pc,
    output logic        error
);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    scan_state_e        state;
    logic [DEPTH_W-1:0] depth;
    logic               dir_q;
    logic [15:0]        start_pc_q;

    logic [15:0] step_base;
    logic [15:0] step_next;
    logic        step_dir;
    logic        wrap;
    logic        is_open;
    logic        is_close;
    logic        matched;
    logic        eval_err;

    // In IDLE the first step is taken from the requester's inputs, later from the scan state.
    always_comb begin
        step_base = (state == S_IDLE) ? start_pc : instr_addr;
        step_dir  = (state == S_IDLE) ? dir      : dir_q;
    end

    PCALU u_pcalu (
        .pc_in    (step_base),
        .PCDecInc (step_dir),
        .pc_out   (step_next)
    );

    assign wrap     = step_wraps(step_base, step_dir);
    assign is_open  = (dir_q == DIR_FWD) ? (instr_data == OP_LBRACK) : (instr_data == OP_RBRACK);
    assign is_close = (dir_q == DIR_FWD) ? (instr_data == OP_RBRACK) : (instr_data == OP_LBRACK);
    assign matched  = is_close && (depth == DEPTH_ONE);
    assign eval_err = (is_open && (depth == DEPTH_MAX)) || (!matched && wrap);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            depth      <= '0;
            dir_q      <= DIR_FWD;
            start_pc_q <= 16'h0000;
            instr_addr <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            match_pc   <= 16'h0000;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dir_q      <= dir;
                        start_pc_q <= start_pc;
                        depth      <= DEPTH_ONE;
                        if (wrap) begin
                            done     <= 1'b1;
                            error    <= 1'b1;
                            match_pc <= start_pc;
                        end else begin
                            instr_addr <= step_next;
                            busy       <= 1'b1;
                            state      <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_EVAL;
                S_EVAL: begin
                    if (eval_err) begin
                        done     <= 1'b1;
                        error    <= 1'b1;
                        match_pc <= start_pc_q;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (matched) begin
                        done     <= 1'b1;
                        match_pc <= instr_addr;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        if (is_open)       depth <= depth + DEPTH_ONE;
                        else if (is_close) depth <= depth - DEPTH_ONE;
                        instr_addr <= step_next;
                        state      <= S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
